spi_rx_slave: RTL and testbench
===============================

# spi_rx_slave

Receives serial frames from an external SPI master and presents each complete word as a parallel value with a one-cycle strobe. It is the receiving end of the team's CS/SCLK/MOSI link, matching the DAC output serialiser's framing: 24 bits, MSB first, CS active-low, SCLK idling high. It sits between the MCU control port pins and the register/control logic, and oversamples the SPI pins in the system clock domain.

## Interface
- DATA_WIDTH, 24, bits per frame; frame is valid only with exactly this many SCLK falling edges.
- TIMEOUT_CYCLES, 1024, i_clock cycles without a SCLK edge while CS is low before abort (used only with the timeout feature).
- i_clock  input  1  system clock; all logic on its rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_SPI_CS  input  1  chip select from master, active-low, asynchronous to i_clock.
- i_SPI_clock  input  1  SPI clock from master, idles high, asynchronous.
- i_SPI_data  input  1  MOSI, asynchronous.
- o_data  output  DATA_WIDTH  last good frame, held until the next good frame.
- o_valid  output  1  one-cycle strobe: o_data updated this cycle.
- o_frame_error  output  1  one-cycle strobe: frame ended with a wrong bit count, or timed out.
- o_busy  output  1  high while a frame is in progress (CS low, synchronised).

## Operation
- All three SPI inputs pass through 2-FF synchronisers. A third register per CS/SCLK gives edge detection. Synchronisers reset to CS=1, SCLK=1, MOSI=0.
- The bit counter is 6 bits wide and saturates at DATA_WIDTH+1. It never wraps.
- State machine:
  - IDLE: o_busy=0. A CS falling edge clears the shift register and bit counter, then goes to SHIFT.
  - SHIFT: o_busy=1.
    - On each SCLK falling edge, shift in MOSI at the LSB (MSB first overall) and increment the counter.
    - SCLK rising edges are ignored; the master changes data on the rising edge.
    - A CS rising edge goes to CHECK.
  - CHECK, one cycle:
    - If count == DATA_WIDTH: load o_data from the shift register and pulse o_valid.
    - Otherwise pulse o_frame_error and leave o_data unchanged.
    - Then go to IDLE.
  - ABORT (timeout feature only): o_busy=1. Wait for the CS rising edge, then go to IDLE with no strobe.
- A SCLK falling edge and a CS rising edge in the same cycle: the bit is shifted and counted first, then CHECK evaluates the updated count.
- A CS falling edge while in CHECK is honoured: the next state is SHIFT, not IDLE. Back-to-back frames need no gap beyond the minimum CS high time.
- An async reset mid-frame:
  - Discards the partial frame and clears o_data to 0.
  - After reset release with CS already low, the block stays in IDLE until a fresh CS falling edge.

## Timing
- Reset values: o_data=0, o_valid=0, o_frame_error=0, o_busy=0, state IDLE.
- Pin-to-edge-detect latency is 3 i_clock cycles.
- o_valid / o_frame_error are asserted 4 cycles after the CS pin rises: 3 cycles detect, 1 cycle CHECK.
- Minimum SCLK high and low time is 3 i_clock cycles each. The DAC serialiser's 10-cycle half-period meets this with margin.
- Minimum CS high between frames is 3 i_clock cycles.
- MOSI must be stable from 3 cycles before to 1 cycle after the SCLK falling edge at the pins.
- Strobes last exactly one cycle. There is no back-pressure; the consumer must capture o_data on o_valid or read it before the next strobe.

## Configuration
- SPI_RX_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in SHIFT. It resets on every SCLK edge and on entry to SHIFT.
  - When it reaches TIMEOUT_CYCLES: pulse o_frame_error once, discard the frame, and go to ABORT.
- SPI_RX_TIMEOUT_EN undefined: no counter, ABORT state absent, and SHIFT waits indefinitely for CS to rise.

## Test plan
- Send 0xA5C3F0 with 10-cycle half-periods → one o_valid pulse, o_data=0xA5C3F0 four cycles after CS rises, o_frame_error never high.
- Send 0x123456 then 0xFEDCBA with a 3-cycle CS gap → two o_valid pulses, o_data reads 0x123456 then 0xFEDCBA.
- Send 23 bits, then 25 bits, then 70 bits → o_frame_error pulses three times, no o_valid, o_data keeps the previous good value.
- Assert i_reset_n low at bit 12 of 0xFFFFFF, release, then send 0x000001 → o_data=0 immediately in reset, then one o_valid with 0x000001.
- With SPI_RX_TIMEOUT_EN and TIMEOUT_CYCLES=64: drop CS, clock 5 bits, hold SCLK high for 100 cycles → o_frame_error at idle cycle 64, o_busy stays 1 until CS rises, no o_valid.
- Drop CS with SCLK held at 3-cycle half-periods sending 0x800001 → o_valid with o_data=0x800001 (minimum timing met).

Source files
------------

// File: rtl/spi_rx_slave.sv
// SPI receive slave: oversamples CS/SCLK/MOSI in the i_clock domain and presents each
// complete DATA_WIDTH-bit, MSB-first frame on o_data with a one-cycle o_valid strobe.
// Optional idle timeout is enabled by defining SPI_RX_TIMEOUT_EN.
module spi_rx_slave #(
  parameter int unsigned DATA_WIDTH = 24
`ifdef SPI_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_SPI_CS,
  input  logic                  i_SPI_clock,
  input  logic                  i_SPI_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

`ifdef SPI_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = 16;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_ABORT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;
`endif

  logic cs_meta, cs_sync, cs_d;
  logic sclk_meta, sclk_sync, sclk_d;
  logic mosi_meta, mosi_sync;
  logic [1:0] fill;

  // Synchronisers plus one delay stage on CS/SCLK for edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_d      <= 1'b1;
      sclk_meta <= 1'b1;
      sclk_sync <= 1'b1;
      sclk_d    <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      fill      <= 2'd0;
    end else begin
      cs_meta   <= i_SPI_CS;
      cs_sync   <= cs_meta;
      cs_d      <= cs_sync;
      sclk_meta <= i_SPI_clock;
      sclk_sync <= sclk_meta;
      sclk_d    <= sclk_sync;
      mosi_meta <= i_SPI_data;
      mosi_sync <= mosi_meta;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // Edges are trusted only once the chain holds real pin samples, so a CS already
  // low at reset release is not mistaken for a fresh falling edge.
  logic primed, cs_fall, cs_rise, sclk_fall;
  assign primed    = (fill == 2'd3);
  assign cs_fall   = primed & cs_d & ~cs_sync;
  assign cs_rise   = primed & ~cs_d & cs_sync;
  assign sclk_fall = primed & sclk_d & ~sclk_sync;

`ifdef SPI_RX_TIMEOUT_EN
  logic sclk_rise;
  logic [IDLE_W-1:0] idle_cnt;
  assign sclk_rise = primed & ~sclk_d & sclk_sync;
`endif

  state_t state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      shreg         <= '0;
      count         <= '0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      o_busy        <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt      <= '0;
`endif
    end else begin
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            shreg  <= '0;
            count  <= '0;
            o_busy <= 1'b1;
            state  <= S_SHIFT;
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end

        S_SHIFT: begin
          if (sclk_fall) begin
            shreg <= {shreg[DATA_WIDTH-2:0], mosi_sync};
            if (count != CNT_SAT) count <= count + CNT_W'(1);
          end
          if (cs_rise) begin
            o_busy <= 1'b0;
            state  <= S_CHECK;
          end
`ifdef SPI_RX_TIMEOUT_EN
          else if (sclk_fall || sclk_rise) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LIMIT - IDLE_W'(1)) begin
            o_frame_error <= 1'b1;
            state         <= S_ABORT;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
`endif
        end

        S_CHECK: begin
          if (count == CNT_FULL) begin
            o_data  <= shreg;
            o_valid <= 1'b1;
          end else begin
            o_frame_error <= 1'b1;
          end
          // A new frame may already have started during the check cycle.
          if (cs_fall) begin
            shreg  <= '0;
            count  <= '0;
            o_busy <= 1'b1;
            state  <= S_SHIFT;
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end

`ifdef SPI_RX_TIMEOUT_EN
        S_ABORT: begin
          if (cs_rise) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
`endif

        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_slave.sv
// Testbench for spi_rx_slave: table of frames driven as an SPI master, with a
// strobe scoreboard and hand-written reset and timeout sequences.
module tb_spi_rx_slave;
  localparam int unsigned DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1;
  logic sclk = 1'b1;
  logic mosi = 1'b0;
  logic [DW-1:0] data;
  logic valid, ferr, busy;

  always #5 clk = ~clk;

  spi_rx_slave #(
    .DATA_WIDTH(DW)
`ifdef SPI_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_SPI_CS(cs),
    .i_SPI_clock(sclk),
    .i_SPI_data(mosi),
    .o_data(data),
    .o_valid(valid),
    .o_frame_error(ferr),
    .o_busy(busy)
  );

  typedef struct {
    bit            is_err;
    logic [DW-1:0] value;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [DW-1:0] value;
    int            nbits;
    int            half;
    int            gap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (rst_n && (valid || ferr)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'b0, valid, ferr}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("strobe_valid", {31'b0, valid}, {31'b0, !e.is_err});
        chk("strobe_error", {31'b0, ferr}, {31'b0, e.is_err});
        if (e.cyc >= 0) chk("strobe_latency", cyc, e.cyc);
        if (!e.is_err) chk("o_data_on_valid", {8'b0, data}, {8'b0, e.value});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [DW-1:0] d, input int nbits, input int half);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      if (i < int'(DW)) b = d[DW-1-i];
      else b = 1'(i & 1);
      mosi = b;
      tick(half);
      sclk = 1'b0;
      tick(half);
      sclk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int nbits, input int half);
    exp_t e;
    cs = 1'b0;
    tick(half);
    chk("busy_in_frame", {31'b0, busy}, 32'h1);
    send_bits(d, nbits, half);
    tick(half);
    cs = 1'b1;
    e.is_err = (nbits != int'(DW));
    e.value  = d;
    e.cyc    = cyc + 4;
    sb.push_back(e);
    if (!e.is_err) model = d;
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{24'hA5C3F0, 24, 10, 20};
    vecs[1] = '{24'h123456, 24, 10, 3};
    vecs[2] = '{24'hFEDCBA, 24, 10, 20};
    vecs[3] = '{24'hABCDEF, 23, 10, 20};
    vecs[4] = '{24'hABCDEF, 25, 10, 20};
    vecs[5] = '{24'hABCDEF, 70, 4, 20};
    vecs[6] = '{24'h800001, 24, 3, 20};

    tick(3);
    chk("reset_o_data", {8'b0, data}, 32'h0);
    chk("reset_o_valid", {31'b0, valid}, 32'h0);
    chk("reset_o_frame_error", {31'b0, ferr}, 32'h0);
    chk("reset_o_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_o_busy", {31'b0, busy}, 32'h0);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].value, vecs[v].nbits, vecs[v].half);
      tick(vecs[v].gap);
      if (vecs[v].gap >= 10) begin
        chk("held_o_data", {8'b0, data}, {8'b0, model});
        chk("post_frame_busy", {31'b0, busy}, 32'h0);
      end
    end

    // Reset mid-frame with CS held low across release.
    cs = 1'b0;
    tick(10);
    send_bits(24'hFFFFFF, 12, 10);
    rst_n = 1'b0;
    #1;
    chk("midreset_o_data", {8'b0, data}, 32'h0);
    chk("midreset_o_busy", {31'b0, busy}, 32'h0);
    model = '0;
    @(negedge clk);
    tick(4);
    rst_n = 1'b1;
    tick(20);
    chk("cs_low_after_reset_busy", {31'b0, busy}, 32'h0);
    cs = 1'b1;
    tick(20);
    chk("after_reset_o_data", {8'b0, data}, 32'h0);
    send_frame(24'h000001, 24, 10);
    tick(20);
    chk("after_reset_frame", {8'b0, data}, 32'h1);

`ifdef SPI_RX_TIMEOUT_EN
    // Stalled frame: SCLK held high long enough to hit the idle timeout.
    cs = 1'b0;
    tick(10);
    send_bits(24'h1F0000, 5, 10);
    e.is_err = 1'b1;
    e.value  = '0;
    e.cyc    = -1;
    sb.push_back(e);
    tick(100);
    chk("abort_busy", {31'b0, busy}, 32'h1);
    chk("abort_queue_drained", sb.size(), 32'h0);
    cs = 1'b1;
    tick(20);
    chk("abort_exit_busy", {31'b0, busy}, 32'h0);
    chk("abort_o_data", {8'b0, data}, 32'h1);
`endif

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick(1);
    chk("scoreboard_empty", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
